// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the command sequencers.
// Contents:
//   - device reply byte constants (ACK, RESEND, device error)
//   - failure cause codes reported on err_code
//   - command sequencer state encoding
package ps2_pkg;

  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_DEV_ERR = 8'hFC;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_RETRY   = 2'd2;
  localparam logic [1:0] ERR_DEVICE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_TX  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAIL     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Bus bundle between the PS/2 command sequencer and its environment.
// Groups three sides:
//   command side : cmd_valid/cmd_ready/cmd_byte0/cmd_byte1/cmd_two,
//                  done/error/err_code completion status
//   transceiver  : tx_data/tx_send/tx_done/tx_error, rx_data/rx_valid
//   keyboard side: resp_data/resp_valid forwarded scan codes
// Modports:
//   slave  - the sequencer's view
//   master - the surrounding logic's view (host, transceiver, keyboard)
interface ps2_cmd_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_byte0;
  logic [7:0] cmd_byte1;
  logic       cmd_two;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_done;
  logic       tx_error;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  modport slave (
    input  cmd_valid, cmd_byte0, cmd_byte1, cmd_two,
    input  tx_done, tx_error, rx_data, rx_valid,
    output cmd_ready, tx_data, tx_send, resp_data, resp_valid,
    output done, error, err_code
  );

  modport master (
    output cmd_valid, cmd_byte0, cmd_byte1, cmd_two,
    output tx_done, tx_error, rx_data, rx_valid,
    input  cmd_ready, tx_data, tx_send, resp_data, resp_valid,
    input  done, error, err_code
  );

endinterface

// File: rtl/ps2_timeout_timer.sv
// Saturating cycle timer used to bound waits on the PS/2 device.
// Ports:
//   clk     - clock, rising edge
//   srst    - synchronous active-high reset, clears the count
//   clear   - restart counting from zero (wins over enable)
//   enable  - count one cycle
//   expired - count has reached TIMEOUT_CYCLES-1; the owner acts on the
//             following edge, so a wait lasts exactly TIMEOUT_CYCLES cycles
module ps2_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != TW'(TIMEOUT_CYCLES))) begin
      // Holds at TIMEOUT_CYCLES instead of wrapping back to zero.
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Sends one- or two-byte host-to-device PS/2 commands through the byte-level
// transceiver, waiting for the device ACK after each byte. RESEND replies and
// transceiver errors are retried up to MAX_RETRY times per byte; a device
// error reply or a wait longer than TIMEOUT_CYCLES fails the command.
// While idle, received bytes are forwarded to the keyboard logic.
// Ports:
//   CLOCK_50 - system clock, rising edge
//   reset    - synchronous active-high reset, abandons any command silently
//   bus      - ps2_cmd_sequencer_if.slave (command, transceiver, scan codes)
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  ps2_cmd_sequencer_if.slave    bus
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  seq_state_t         state_reg;
  logic [7:0]         byte0_reg;
  logic [7:0]         byte1_reg;
  logic               two_reg;
  logic               idx_reg;
  logic [RETRY_W-1:0] retry_reg;
  logic [7:0]         tx_data_reg;
  logic               tx_send_reg;
  logic               done_reg;
  logic               error_reg;
  logic [1:0]         err_code_reg;
  logic [7:0]         resp_data_reg;
  logic               resp_valid_reg;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;
  logic retry_exhausted;

  // Timer restarts for each transmission and again once the byte is out,
  // so the tx wait and the ACK wait are bounded separately.
  assign timer_clear  = (state_reg == ST_SEND) ||
                        ((state_reg == ST_WAIT_TX) && bus.tx_done);
  assign timer_enable = (state_reg == ST_WAIT_TX) || (state_reg == ST_WAIT_ACK);
  assign retry_exhausted = (retry_reg == RETRY_W'(MAX_RETRY));

  ps2_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (CLOCK_50),
    .srst    (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      byte0_reg      <= 8'h00;
      byte1_reg      <= 8'h00;
      two_reg        <= 1'b0;
      idx_reg        <= 1'b0;
      retry_reg      <= '0;
      tx_data_reg    <= 8'h00;
      tx_send_reg    <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      err_code_reg   <= ERR_NONE;
      resp_data_reg  <= 8'h00;
      resp_valid_reg <= 1'b0;
    end else begin
      // Pulse outputs default low; done/error are raised on the edge that
      // enters DONE/FAIL so they are visible for exactly that state's cycle.
      tx_send_reg    <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= bus.rx_data;
          end
          if (bus.cmd_valid) begin
            byte0_reg <= bus.cmd_byte0;
            byte1_reg <= bus.cmd_byte1;
            two_reg   <= bus.cmd_two;
            idx_reg   <= 1'b0;
            retry_reg <= '0;
            state_reg <= ST_SEND;
          end
        end

        ST_SEND: begin
          tx_data_reg <= idx_reg ? byte1_reg : byte0_reg;
          tx_send_reg <= 1'b1;
          state_reg   <= ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          if (bus.tx_done) begin
            state_reg <= ST_WAIT_ACK;
          end else if (bus.tx_error) begin
            if (retry_exhausted) begin
              state_reg    <= ST_FAIL;
              error_reg    <= 1'b1;
              err_code_reg <= ERR_RETRY;
            end else begin
              retry_reg <= retry_reg + 1'b1;
              state_reg <= ST_SEND;
            end
          end else if (timer_expired) begin
            state_reg    <= ST_FAIL;
            error_reg    <= 1'b1;
            err_code_reg <= ERR_TIMEOUT;
          end
        end

        ST_WAIT_ACK: begin
          // Unrecognised bytes fall through and are dropped; the timer
          // keeps running so a chatty device cannot stall the command.
          if (bus.rx_valid && (bus.rx_data == PS2_ACK)) begin
            if (!idx_reg && two_reg) begin
              idx_reg   <= 1'b1;
              retry_reg <= '0;
              state_reg <= ST_SEND;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end
          end else if (bus.rx_valid && (bus.rx_data == PS2_RESEND)) begin
            if (retry_exhausted) begin
              state_reg    <= ST_FAIL;
              error_reg    <= 1'b1;
              err_code_reg <= ERR_RETRY;
            end else begin
              retry_reg <= retry_reg + 1'b1;
              state_reg <= ST_SEND;
            end
          end else if (bus.rx_valid && (bus.rx_data == PS2_DEV_ERR)) begin
            state_reg    <= ST_FAIL;
            error_reg    <= 1'b1;
            err_code_reg <= ERR_DEVICE;
          end else if (timer_expired) begin
            state_reg    <= ST_FAIL;
            error_reg    <= 1'b1;
            err_code_reg <= ERR_TIMEOUT;
          end
        end

        ST_DONE: state_reg <= ST_IDLE;
        ST_FAIL: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state_reg == ST_IDLE);
  assign bus.tx_data    = tx_data_reg;
  assign bus.tx_send    = tx_send_reg;
  assign bus.done       = done_reg;
  assign bus.error      = error_reg;
  assign bus.err_code   = err_code_reg;
  assign bus.resp_data  = resp_data_reg;
  assign bus.resp_valid = resp_valid_reg;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Scoreboard bench for ps2_cmd_sequencer. The main process plays host,
// transceiver and device; a reference model decides, from the device
// reactions it picks, which bytes must be transmitted and how each command
// ends. A separate monitor pops and compares on every tx_send, done/error
// and resp_valid it observes.
module tb_ps2_cmd_sequencer;

  localparam int TIMEOUT   = 100;
  localparam int MAX_RETRY = 3;

  typedef enum int {R_ACK, R_RESEND, R_TXERR, R_DEVERR, R_NOACK, R_NOTX, R_HANG} reaction_t;
  typedef struct { bit is_err; logic [1:0] code; } outcome_t;
  typedef struct { logic [7:0] data; int when; } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   to_deadline = -1;
  int   tx_cyc = 0;
  logic [1:0] last_code = 2'd0;
  bit   force_junk = 1'b0;

  logic [7:0] exp_tx[$];
  outcome_t   exp_out[$];
  resp_t      exp_resp[$];
  reaction_t  script_q[$];

  ps2_cmd_sequencer_if bus();

  ps2_cmd_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRY      (MAX_RETRY)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_send) begin
        if (exp_tx.size() == 0) check("spurious_tx_send", 32'(bus.tx_send), 32'd0);
        else check("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
      end
      if (bus.done || bus.error) begin
        if (exp_out.size() == 0) begin
          check("spurious_outcome", 32'({bus.done, bus.error}), 32'd0);
        end else begin
          outcome_t o;
          o = exp_out.pop_front();
          check("outcome_is_error", 32'(bus.error), 32'(o.is_err));
          check("done_error_exclusive", 32'(bus.done & bus.error), 32'd0);
          if (o.is_err) begin
            check("err_code", 32'(bus.err_code), 32'(o.code));
            last_code = o.code;
            if (o.code == 2'd1) check("timeout_cycle", 32'(cyc), 32'(to_deadline));
          end else begin
            check("err_code_held", 32'(bus.err_code), 32'(last_code));
          end
        end
      end
      if (bus.resp_valid) begin
        if (exp_resp.size() == 0) begin
          check("spurious_resp", 32'(bus.resp_valid), 32'd0);
        end else begin
          resp_t r;
          r = exp_resp.pop_front();
          check("resp_data", 32'(bus.resp_data), 32'(r.data));
          check("resp_latency", 32'(cyc), 32'(r.when));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.tx_done = 1'b0; bus.tx_error = 1'b0; bus.rx_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    exp_tx.delete(); exp_out.delete(); exp_resp.delete();
    last_code = 2'd0;
    to_deadline = -1;
  endtask

  task automatic drive_rx(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic fwd(input logic [7:0] b);
    resp_t r;
    r.data = b;
    r.when = cyc + 1;
    exp_resp.push_back(r);
    drive_rx(b);
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 60 && !ok; w++) begin
      @(negedge clk);
      if (bus.tx_send) begin
        ok = 1'b1;
        tx_cyc = cyc;
      end
    end
    if (!ok) check("tx_send_wait", 32'd0, 32'd1);
  endtask

  function automatic reaction_t next_reaction();
    int r;
    if (script_q.size() != 0) return script_q.pop_front();
    r = int'($urandom_range(0, 99));
    if (r < 50) return R_ACK;
    if (r < 78) return R_RESEND;
    if (r < 86) return R_TXERR;
    if (r < 92) return R_DEVERR;
    if (r < 96) return R_NOACK;
    return R_NOTX;
  endfunction

  // Issue one command; the model walks the device reactions byte by byte.
  task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input bit two, input bit sim_rx);
    reaction_t rq[$];
    reaction_t r;
    int idx = 0, retry = 0, w;
    bit fin = 1'b0, ok, hang = 1'b0;
    outcome_t o;
    string res = "none";

    while (!fin) begin
      exp_tx.push_back(idx != 0 ? b1 : b0);
      r = next_reaction();
      rq.push_back(r);
      o.is_err = 1'b1;
      o.code = 2'd0;
      case (r)
        R_ACK:
          if (idx == 0 && two) begin idx = 1; retry = 0; end
          else begin o.is_err = 1'b0; fin = 1'b1; end
        R_RESEND, R_TXERR:
          if (retry == MAX_RETRY) begin o.code = 2'd2; fin = 1'b1; end
          else retry++;
        R_DEVERR: begin o.code = 2'd3; fin = 1'b1; end
        R_NOACK, R_NOTX: begin o.code = 2'd1; fin = 1'b1; end
        default: begin hang = 1'b1; fin = 1'b1; end
      endcase
      if (fin && !hang) begin
        exp_out.push_back(o);
        res = o.is_err ? $sformatf("error code %0d", o.code) : "done";
      end
    end
    $display("cmd b0=%02h b1=%02h two=%0d sim_rx=%0d transmissions=%0d expect=%s",
             b0, b1, two, sim_rx, rq.size(), res);

    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte0 = b0;
    bus.cmd_byte1 = b1;
    bus.cmd_two   = two;
    if (sim_rx) begin
      resp_t rr;
      rr.data = 8'h1C;
      rr.when = cyc + 1;
      exp_resp.push_back(rr);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h1C;
    end
    step();
    bus.cmd_valid = 1'b0;
    bus.rx_valid  = 1'b0;

    foreach (rq[k]) begin
      wait_tx(ok);
      if (!ok) begin do_reset(); return; end
      step();
      if (rq[k] == R_NOTX) begin
        to_deadline = tx_cyc + TIMEOUT;
      end else begin
        repeat ($urandom_range(0, 2)) step();
        if (rq[k] == R_TXERR) begin
          bus.tx_error = 1'b1; step(); bus.tx_error = 1'b0;
        end else begin
          bus.tx_done = 1'b1;
          if (rq[k] == R_NOACK) to_deadline = cyc + TIMEOUT + 1;
          step();
          bus.tx_done = 1'b0;
          repeat ($urandom_range(0, 2)) step();
          if (rq[k] == R_ACK) begin
            if (force_junk || $urandom_range(0, 1) == 1) begin
              drive_rx(8'($urandom_range(0, 127)));
              repeat ($urandom_range(0, 2)) step();
            end
            drive_rx(8'hFA);
          end else if (rq[k] == R_RESEND) begin
            drive_rx(8'hFE);
          end else if (rq[k] == R_DEVERR) begin
            drive_rx(8'hFC);
          end
        end
      end
    end

    if (hang) begin
      // Reset while the sequencer waits for the ACK.
      repeat (5) step();
      reset = 1'b1;
      step();
      check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_mid_done", 32'(bus.done), 32'd0);
      check("rst_mid_error", 32'(bus.error), 32'd0);
      reset = 1'b0;
      last_code = 2'd0;
      step();
      return;
    end

    w = 0;
    while (exp_out.size() != 0 && w < 400) begin step(); w++; end
    if (exp_out.size() != 0) begin
      check("outcome_wait", 32'(exp_out.size()), 32'd0);
      do_reset();
      return;
    end
    step(); step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_byte0 = 8'h00; bus.cmd_byte1 = 8'h00; bus.cmd_two = 1'b0;
    bus.tx_done = 1'b0; bus.tx_error = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_tx_send", 32'(bus.tx_send), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    reset = 1'b0;
    step();

    // Directed: two-byte LED command.
    script_q = '{R_ACK, R_ACK};
    run_cmd(8'hED, 8'h07, 1'b1, 1'b0);
    // Two resends then ACK on a reset command.
    script_q = '{R_RESEND, R_RESEND, R_ACK};
    run_cmd(8'hFF, 8'h00, 1'b0, 1'b0);
    // Resends until retries run out.
    script_q = '{R_RESEND, R_RESEND, R_RESEND, R_RESEND};
    run_cmd(8'hFF, 8'h00, 1'b0, 1'b0);
    // Byte transmitted but no ACK ever arrives.
    script_q = '{R_NOACK};
    run_cmd(8'hF3, 8'h20, 1'b1, 1'b0);
    // Device error reply.
    script_q = '{R_DEVERR};
    run_cmd(8'hF3, 8'h20, 1'b1, 1'b0);
    // Done after failures keeps the last err_code.
    script_q = '{R_ACK};
    run_cmd(8'hF4, 8'h00, 1'b0, 1'b0);
    // Scan code in IDLE.
    fwd(8'h1C);
    step();
    // Stray byte while waiting for ACK is dropped.
    force_junk = 1'b1;
    script_q = '{R_ACK};
    run_cmd(8'hEE, 8'h00, 1'b0, 1'b0);
    force_junk = 1'b0;
    // Command and scan code in the same cycle.
    script_q = '{R_ACK, R_ACK};
    run_cmd(8'hED, 8'h02, 1'b1, 1'b1);
    // Reset mid-command, then a normal command.
    script_q = '{R_HANG};
    run_cmd(8'hED, 8'h05, 1'b1, 1'b0);
    script_q = '{R_TXERR, R_ACK, R_ACK};
    run_cmd(8'hED, 8'h04, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) fwd(8'($urandom_range(0, 255)));
      run_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    repeat (4) step();
    check("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
    check("exp_out_drained", 32'(exp_out.size()), 32'd0);
    check("exp_resp_drained", 32'(exp_resp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
